// File: rtl/dcache_stb_port.sv
// dcache_stb_port: store-buffer write port into a byte-lane data array.
// A store is captured in IDLE, held through WAIT_CYCLES wait states,
// written in WRITE, and acknowledged with a one-cycle pulse in ACK.
// Out-of-range addresses are acknowledged with err and never written.
// Optional feature macro: DCACHE_STB_PORT_PERF_CNT_EN enables the
// good-store counter on perf_store_cnt; otherwise that output is tied to 0.
module dcache_stb_port #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter int MEM_DEPTH      = 64,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stb2dcache_req,
  input  logic                          stb2dcache_w_en,
  input  logic [ADDR_WIDTH-1:0]         stb2dcache_addr,
  input  logic [DATA_WIDTH-1:0]         stb2dcache_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0]     stb2dcache_sel_byte,
  output logic                          dcache2stb_ack,
  output logic                          dcache2stb_err,
  output logic                          busy,
  input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0]         dbg_rdata,
  output logic [31:0]                   perf_store_cnt
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [3:0]                wait_cnt;
  logic [ADDR_WIDTH-1:0]     hold_addr;
  logic [DATA_WIDTH-1:0]     hold_wdata;
  logic [BYTE_SEL_WIDTH-1:0] hold_sel;
  logic                      ack_q;
  logic                      err_q;
  logic                      busy_q;
  logic                      capture;
  logic                      out_of_range;
  logic                      do_write;
  logic [IDX_W-1:0]          word_idx;

  logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];

  assign capture      = (state == IDLE) && stb2dcache_req && stb2dcache_w_en;
  assign word_idx     = hold_addr[IDX_W+1:2];
  // Any set bit above the word index (and byte offset) is outside the array.
  assign out_of_range = |(hold_addr >> (IDX_W + 2));
  assign do_write     = (state == WRITE) && !out_of_range;

  // Next-state selection; request inputs only matter in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = (WAIT_CYCLES == 0) ? WRITE : WAIT;
      WAIT:    if (wait_cnt <= 4'd1) state_nxt = WRITE;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and registered status outputs, derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ack_q  <= (state_nxt == ACK);
      err_q  <= (state_nxt == ACK) && out_of_range;
      busy_q <= (state_nxt != IDLE);
    end
  end

  // Wait-state counter: loaded on capture, counts down while in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (capture) begin
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Holding registers for the in-flight store (datapath, not reset).
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_addr  <= stb2dcache_addr;
      hold_wdata <= stb2dcache_wdata;
      hold_sel   <= stb2dcache_sel_byte;
    end
  end

  // Byte-lane array write on the WRITE exit edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned i = 0; i < BYTE_SEL_WIDTH; i++) begin
        if (hold_sel[i]) mem[word_idx][i*8 +: 8] <= hold_wdata[i*8 +: 8];
      end
    end
  end

  assign dcache2stb_ack = ack_q;
  assign dcache2stb_err = err_q;
  assign busy           = busy_q;
  assign dbg_rdata      = mem[dbg_addr];

`ifdef DCACHE_STB_PORT_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Count error-free acknowledgements; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (ack_q && !err_q) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_store_cnt = perf_cnt;
`else
  assign perf_store_cnt = '0;
`endif

endmodule
